// File: rtl/mac_tcdm_sink.sv
// Write-side streamer: drains the engine's result stream into TCDM at strided addresses.
// One output request register gives 1 word/cycle when grants arrive back-to-back.
module mac_tcdm_sink #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int CNT_WIDTH    = 11,
  parameter int STRIDE_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [CNT_WIDTH-1:0]    len_i,
  input  logic [STRIDE_WIDTH-1:0] stride_i,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  input  logic [DATA_WIDTH/8-1:0] in_strb_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  output logic [DATA_WIDTH-1:0]   tcdm_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNT_WIDTH-1:0]    cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                  state;
  logic [CNT_WIDTH-1:0]    len_q;
  logic [CNT_WIDTH-1:0]    acc_cnt;
  logic [CNT_WIDTH-1:0]    gnt_cnt;
  logic [STRIDE_WIDTH-1:0] stride_q;
  logic [ADDR_WIDTH-1:0]   addr_ptr;
  logic                    req_q;
  logic [ADDR_WIDTH-1:0]   add_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic                    done_q;
  logic                    accept;
  logic                    grant;
  logic                    last_grant;

  // Valid/ready: a beat transfers on the edge where in_valid_i && in_ready_o;
  // ready may look at gnt because a granted slot frees the request register this cycle.
  assign grant      = req_q && tcdm_gnt_i;
  assign in_ready_o = (state == RUN) && (acc_cnt < len_q) && (!req_q || tcdm_gnt_i);
  assign accept     = in_valid_i && in_ready_o;
  assign last_grant = grant && ((gnt_cnt + CNT_WIDTH'(1)) == len_q);

  assign tcdm_req_o  = req_q;
  assign tcdm_add_o  = add_q;
  assign tcdm_data_o = data_q;
  assign tcdm_be_o   = be_q;
  assign tcdm_wen_o  = 1'b0;
  assign busy_o      = (state != IDLE);
  assign done_o      = done_q;
  assign cnt_o       = gnt_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      len_q    <= '0;
      acc_cnt  <= '0;
      gnt_cnt  <= '0;
      stride_q <= '0;
      addr_ptr <= '0;
      req_q    <= 1'b0;
      add_q    <= '0;
      data_q   <= '0;
      be_q     <= '0;
      done_q   <= 1'b0;
    end else if (clear_i) begin
      // Abort: any un-granted request is simply dropped.
      state   <= IDLE;
      acc_cnt <= '0;
      gnt_cnt <= '0;
      req_q   <= 1'b0;
      add_q   <= '0;
      data_q  <= '0;
      be_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            len_q    <= len_i;
            stride_q <= stride_i;
            addr_ptr <= base_addr_i;
            acc_cnt  <= '0;
            gnt_cnt  <= '0;
            if (len_i == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            req_q    <= 1'b1;
            add_q    <= addr_ptr;
            data_q   <= in_data_i;
            be_q     <= in_strb_i;
            addr_ptr <= addr_ptr + ADDR_WIDTH'(stride_q);
            acc_cnt  <= acc_cnt + CNT_WIDTH'(1);
          end else if (grant) begin
            req_q <= 1'b0;
          end
          if (grant) begin
            gnt_cnt <= gnt_cnt + CNT_WIDTH'(1);
          end
          // The final grant can never coincide with an accept, so req is already dropping.
          if (last_grant) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tcdm_sink.sv
// Bench for mac_tcdm_sink: strided write jobs with stream gaps, grant stalls,
// clear/reset aborts and ignored starts, checked against a write scoreboard.
module tb_mac_tcdm_sink;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 11;
  localparam int SW = 16;
  localparam int BW = DW / 8;
  localparam int IW = AW + DW + BW;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [CW-1:0] len_i;
  logic [SW-1:0] stride_i;
  logic [DW-1:0] in_data_i;
  logic [BW-1:0] in_strb_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          tcdm_req_o;
  logic          tcdm_gnt_i;
  logic [AW-1:0] tcdm_add_o;
  logic          tcdm_wen_o;
  logic [BW-1:0] tcdm_be_o;
  logic [DW-1:0] tcdm_data_o;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] cnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;
  logic [IW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mac_tcdm_sink #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .STRIDE_WIDTH(SW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .len_i(len_i), .stride_i(stride_i),
    .in_data_i(in_data_i), .in_strb_i(in_strb_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o),
    .tcdm_data_o(tcdm_data_o), .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o)
  );

  always @(negedge clk) begin
    if (done_o === 1'b1) done_seen <= done_seen + 1;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_add"}, IW'({tcdm_req_o, tcdm_add_o}), '0);
    check({tag, "_data_be"}, IW'({tcdm_data_o, tcdm_be_o, tcdm_wen_o}), '0);
    check({tag, "_ctl"}, IW'({busy_o, done_o, cnt_o, in_ready_o}), '0);
  endtask

  // ---------------- driver ----------------
  // vmode: 0 always valid, 1 toggling, 2 random. gmode: 0 always grant (with optional stall), 1 random.
  // abort: 0 none, 1 clear after 3 grants, 2 reset after 3 grants.
  task automatic run_job(input logic [AW-1:0] base, input int len, input logic [SW-1:0] stride,
                         input int vmode, input int gmode, input int stall_idx, input int stall_cyc,
                         input bit consec, input bit ign_start, input int abort);
    logic [AW-1:0] exp_addr;
    logic [IW-1:0] hold, cur, item;
    int nacc, ngr, first_g, last_g, done_c, stall_left, done0;
    bit fin, prev_stall, aborted;
    done0 = done_seen; exp_addr = base; nacc = 0; ngr = 0;
    first_g = -1; last_g = -1; done_c = -1; stall_left = stall_cyc;
    fin = 1'b0; prev_stall = 1'b0; aborted = 1'b0; hold = '0;
    start_i = 1'b1; base_addr_i = base; len_i = CW'(len); stride_i = stride;
    @(posedge clk);
    for (int c = 0; c < 300 && !fin && !aborted; c++) begin
      #1;
      start_i     = ign_start && (c == 2 || done_o);
      base_addr_i = $urandom;
      len_i       = CW'($urandom_range(0, 2047));
      stride_i    = SW'($urandom);
      if (c == 0) check("start_busy", IW'(busy_o), IW'(1));
      if (abort == 1 && ngr == 3) begin
        clear_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; tcdm_gnt_i = 1'b0;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        check("clear_req", IW'(tcdm_req_o), '0);
        check("clear_busy", IW'(busy_o), '0);
        check("clear_cnt", IW'(cnt_o), '0);
        check("clear_done", IW'(done_o), '0);
        exp_q.delete();
        aborted = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("clear_no_done", IW'(done_seen - done0), '0);
      end else if (abort == 2 && ngr == 3) begin
        rst_ni = 1'b0;
        #1;
        check_all_zero("midjob_rst");
        exp_q.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        aborted = 1'b1;
      end else begin
        in_valid_i = (vmode == 0) ? 1'b1 : (vmode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
        in_data_i  = DW'(nacc + 1);
        in_strb_i  = BW'($urandom_range(1, 15));
        if (gmode == 0 && tcdm_req_o && ngr == stall_idx && stall_left > 0) begin
          tcdm_gnt_i = 1'b0;
          stall_left--;
        end else begin
          tcdm_gnt_i = (gmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        #1;
        cur = {tcdm_add_o, tcdm_data_o, tcdm_be_o};
        if (prev_stall) check("stall_hold", cur, hold);
        if (tcdm_req_o && !tcdm_gnt_i) begin
          hold = cur;
          prev_stall = 1'b1;
          check("stall_ready", IW'(in_ready_o), '0);
        end else begin
          prev_stall = 1'b0;
        end
        if (in_valid_i && in_ready_o) begin
          exp_q.push_back({exp_addr, in_data_i, in_strb_i});
          exp_addr = exp_addr + AW'(stride);
          nacc++;
        end
        if (tcdm_req_o && tcdm_gnt_i) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", IW'(1), '0);
          end else begin
            item = exp_q.pop_front();
            check("write", cur, item);
          end
          ngr++;
          if (first_g < 0) first_g = c;
          last_g = c;
        end
        if (done_o) begin
          done_c = c;
          fin = 1'b1;
          check("done_req", IW'(tcdm_req_o), '0);
        end
        @(posedge clk);
      end
    end
    if (abort == 0) begin
      check("done_seen", IW'(fin), IW'(1));
      #1;
      start_i = 1'b0; in_valid_i = 1'b1;
      #1;
      check("idle_busy", IW'(busy_o), '0);
      check("idle_done", IW'(done_o), '0);
      check("idle_ready", IW'(in_ready_o), '0);
      check("final_cnt", IW'(cnt_o), IW'(len));
      check("accepted", IW'(nacc), IW'(len));
      check("sb_drained", IW'(exp_q.size()), '0);
      check("done_pulses", IW'(done_seen - done0), IW'(1));
      check("done_lat", IW'(done_c), (len > 0) ? IW'(last_g + 1) : '0);
      if (consec) check("consec", IW'(last_g - first_g), IW'(len - 1));
      in_valid_i = 1'b0;
    end
    start_i = 1'b0; in_valid_i = 1'b0; tcdm_gnt_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0;
    stride_i = '0; in_data_i = '0; in_strb_i = '0; in_valid_i = 1'b0; tcdm_gnt_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    run_job(32'h0000_1000, 4, 16'd4, 0, 0, -1, 0, 1'b1, 1'b0, 0);
    run_job(32'h0000_1000, 4, 16'd4, 0, 0, 1, 3, 1'b0, 1'b0, 0);
    run_job(32'hFFFF_FFF8, 3, 16'd8, 1, 0, -1, 0, 1'b0, 1'b0, 0);
    run_job(32'h0000_2000, 0, 16'd4, 0, 0, -1, 0, 1'b0, 1'b0, 0);
    run_job(32'h0000_3000, 2, 16'd0, 0, 0, -1, 0, 1'b1, 1'b0, 0);
    run_job(32'h0000_4000, 8, 16'd4, 0, 0, -1, 0, 1'b0, 1'b0, 1);
    run_job(32'h0000_5000, 5, 16'd12, 0, 0, -1, 0, 1'b1, 1'b0, 0);
    run_job(32'h0000_6000, 8, 16'd4, 0, 0, -1, 0, 1'b0, 1'b0, 2);
    #1;
    check_all_zero("after_rst");
    @(posedge clk);
    #1;
    run_job(32'h0000_7000, 6, 16'd4, 0, 0, -1, 0, 1'b1, 1'b1, 0);
    run_job(32'h0000_8000, 7, 16'd16, 2, 1, -1, 0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      run_job($urandom, $urandom_range(1, 24), SW'($urandom), 2, 1, -1, 0, 1'b0,
              1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
